// File: rtl/alu_seq_top.sv
// alu_seq_top: debounced button sequencer (A, B, opcode, execute, show) around one alu instance
module alu #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH = 6
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [DATA_WIDTH-1:0] y,
    output logic [2:0]            flags
);
    logic [DATA_WIDTH:0] sum, dif;
    logic c;
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    always_comb begin
        y = '0;
        c = 1'b0;
        case (op)
            OP_WIDTH'(6'b100000): {c, y} = sum;
            OP_WIDTH'(6'b100010): {c, y} = dif;
            OP_WIDTH'(6'b100100): y = a & b;
            OP_WIDTH'(6'b100101): y = a | b;
            OP_WIDTH'(6'b100110): y = a ^ b;
            OP_WIDTH'(6'b100111): y = ~(a | b);
            OP_WIDTH'(6'b000010): y = a >> b;
            OP_WIDTH'(6'b000011): y = $signed(a) >>> b;
            default: ;
        endcase
    end
    assign flags = {y[DATA_WIDTH-1], ~|y, c};
endmodule

module alu_seq_top #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_sw,
    input  logic [2:0]            i_btn,
    output logic [DATA_WIDTH-1:0] o_led,
    output logic [2:0]            o_flags,
    output logic                  o_valid,
    output logic                  o_err,
    output logic [2:0]            o_state,
    output logic                  o_acc
);
    localparam logic [2:0] LOAD_A = 3'd0;
    localparam logic [2:0] LOAD_B = 3'd1;
    localparam logic [2:0] LOAD_OP = 3'd2;
    localparam logic [2:0] EXEC = 3'd3;
    localparam logic [2:0] SHOW = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(6'b100000);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [2:0] s1, s2, lvl, lvl_d, pulse, state, f;
    logic [CW-1:0] cnt [3];
    logic [DATA_WIDTH-1:0] a, b, y;
    logic [OP_WIDTH-1:0] op, sw_op;
    logic clr, tog, ent, legal;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= '0;
            s2 <= '0;
            lvl <= '0;
            lvl_d <= '0;
            pulse <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= i_btn;
            s2 <= s1;
            lvl_d <= lvl;
            pulse <= lvl & ~lvl_d;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == lvl[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end
    assign clr = pulse[1];
    assign tog = pulse[2] & ~pulse[1];
    assign ent = pulse[0] & ~|pulse[2:1];
    assign sw_op = i_sw[OP_WIDTH-1:0];
    assign legal = sw_op inside {OP_WIDTH'(6'b100000), OP_WIDTH'(6'b100010), OP_WIDTH'(6'b100100),
                                 OP_WIDTH'(6'b100101), OP_WIDTH'(6'b100110), OP_WIDTH'(6'b000011),
                                 OP_WIDTH'(6'b000010), OP_WIDTH'(6'b100111)};
    assign o_state = state;
    assign o_valid = state == SHOW;
    alu #(.DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(OP_WIDTH)) u_alu (.a(a), .b(b), .op(op), .y(y), .flags(f));
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_acc <= 1'b0;
        else if (tog) o_acc <= ~o_acc;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= LOAD_A;
            a <= '0;
            b <= '0;
            op <= OP_ADD;
            o_led <= '0;
            o_flags <= '0;
            o_err <= 1'b0;
        end else if (clr) begin
            state <= LOAD_A;
            a <= '0;
            b <= '0;
            op <= OP_ADD;
            o_led <= '0;
            o_flags <= '0;
            o_err <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (ent) begin
                    a <= i_sw;
                    state <= LOAD_B;
                end
                LOAD_B: if (ent) begin
                    b <= i_sw;
                    state <= LOAD_OP;
                end
                LOAD_OP: if (ent) begin
                    o_err <= ~legal;
                    if (legal) begin
                        op <= sw_op;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    o_led <= y;
                    o_flags <= f;
                    state <= SHOW;
                end
                SHOW: if (ent) begin
                    if (o_acc) a <= o_led;
                    state <= o_acc ? LOAD_B : LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_top.sv
// tb_alu_seq_top: scenario and randomized checks of alu_seq_top against a behavioural alu model
module tb_alu_seq_top;
    localparam int D = 4;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic [7:0] i_sw = '0;
    logic [2:0] i_btn = '0;
    logic [7:0] o_led;
    logic [2:0] o_flags, o_state;
    logic o_valid, o_err, o_acc;
    int checks = 0;
    int failures = 0;
    logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

    always #5 i_clk = ~i_clk;

    alu_seq_top #(.DATA_WIDTH(8), .OP_WIDTH(6), .DEBOUNCE_CYCLES(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sw(i_sw), .i_btn(i_btn), .o_led(o_led),
        .o_flags(o_flags), .o_valid(o_valid), .o_err(o_err), .o_state(o_state), .o_acc(o_acc)
    );

    // Returns {negative, zero, carry, result}; SUB carry is the borrow (a < b)
    function automatic logic [10:0] alu_ref(input int a, input int b, input logic [5:0] op);
        int r, s;
        bit c;
        c = 0;
        r = 0;
        s = (a > 127) ? a - 256 : a;
        case (op)
            6'h20: begin r = a + b; c = r > 255; end
            6'h22: begin r = a - b; c = a < b; end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = (b > 7) ? 0 : a / (1 << b);
            6'h03: r = s >>> ((b > 7) ? 7 : b);
            default: r = 0;
        endcase
        r = r & 255;
        return {r[7], r == 0, c, r[7:0]};
    endfunction

    task automatic press(input logic [2:0] btns, input logic [7:0] sw);
        i_sw = sw;
        i_btn = btns;
        repeat (10) @(negedge i_clk);
        i_btn = '0;
        repeat (12) @(negedge i_clk);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        press(3'b001, a);
        press(3'b001, b);
        press(3'b001, op);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL rst_state_held got=%0d exp=0", o_state); end
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++; if ({o_led, o_flags, o_valid, o_err, o_acc} !== 14'd0) begin failures++; $display("FAIL rst_outputs got=%h exp=0", {o_led, o_flags, o_valid, o_err, o_acc}); end
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", o_state); end
        checks++; if (dut.op !== 6'h20) begin failures++; $display("FAIL rst_op got=%h exp=20", dut.op); end
    endtask

    task automatic test_basic;
        int at_valid = 0;
        logic [2:0] st7 = 3'd7, st8 = 3'd7;
        press(3'b001, 8'h05);
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL basic_load_b got=%0d exp=1", o_state); end
        press(3'b001, 8'h03);
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL basic_load_op got=%0d exp=2", o_state); end
        i_sw = 8'h20;
        i_btn = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            @(posedge i_clk);
            #1;
            if (k == 7) st7 = o_state;
            if (k == 8) st8 = o_state;
            if (o_valid && at_valid == 0) at_valid = k;
        end
        i_btn = '0;
        repeat (12) @(negedge i_clk);
        checks++; if (at_valid != D + 5) begin failures++; $display("FAIL basic_valid_latency got=%0d exp=%0d", at_valid, D + 5); end
        checks++; if (st7 !== 3'd2) begin failures++; $display("FAIL basic_state_pulse_cycle got=%0d exp=2", st7); end
        checks++; if (st8 !== 3'd3) begin failures++; $display("FAIL basic_state_exec got=%0d exp=3", st8); end
        checks++; if (o_led !== 8'h08) begin failures++; $display("FAIL basic_led got=%h exp=08", o_led); end
        checks++; if (o_flags !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b exp=000", o_flags); end
        press(3'b001, 8'h00);
        checks++; if (o_state !== 3'd0 || o_valid !== 1'b0) begin failures++; $display("FAIL basic_return got=%0d/%b exp=0/0", o_state, o_valid); end
    endtask

    task automatic test_carry_clear;
        run_op(8'hFF, 8'h01, 8'h20);
        checks++; if (o_led !== 8'h00) begin failures++; $display("FAIL carry_led got=%h exp=00", o_led); end
        checks++; if (o_flags !== 3'b011) begin failures++; $display("FAIL carry_flags got=%b exp=011", o_flags); end
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL carry_valid got=%b exp=1", o_valid); end
        press(3'b010, 8'h00);
        checks++; if (o_led !== 8'h00 || o_flags !== 3'b000) begin failures++; $display("FAIL clear_outputs got=%h/%b exp=00/000", o_led, o_flags); end
        checks++; if (o_state !== 3'd0 || o_valid !== 1'b0) begin failures++; $display("FAIL clear_state got=%0d/%b exp=0/0", o_state, o_valid); end
    endtask

    task automatic test_opcode_err;
        logic [10:0] e;
        e = alu_ref(3, 5, 6'h22);
        press(3'b001, 8'h03);
        press(3'b001, 8'h05);
        press(3'b001, 8'h3F);
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL err_stay got=%0d exp=2", o_state); end
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", o_err); end
        press(3'b001, 8'h22);
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", o_err); end
        checks++; if (o_led !== 8'hFE || o_led !== e[7:0]) begin failures++; $display("FAIL sub_led got=%h exp=fe", o_led); end
        checks++; if (o_flags !== e[10:8] || o_flags[2] !== 1'b1) begin failures++; $display("FAIL sub_flags got=%b exp=%b", o_flags, e[10:8]); end
        press(3'b001, 8'h00);
    endtask

    task automatic test_debounce;
        i_btn = 3'b001;
        repeat (3) @(negedge i_clk);
        i_btn = '0;
        repeat (15) @(negedge i_clk);
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL glitch_state got=%0d exp=0", o_state); end
        press(3'b001, 8'h44);
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL held_one_step got=%0d exp=1", o_state); end
        repeat (20) @(negedge i_clk);
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL held_no_repeat got=%0d exp=1", o_state); end
        press(3'b010, 8'h00);
    endtask

    task automatic test_acc;
        press(3'b100, 8'h00);
        checks++; if (o_acc !== 1'b1) begin failures++; $display("FAIL acc_on got=%b exp=1", o_acc); end
        run_op(8'h01, 8'h01, 8'h20);
        checks++; if (o_led !== 8'h02) begin failures++; $display("FAIL acc_first got=%h exp=02", o_led); end
        press(3'b001, 8'h00);
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL acc_to_load_b got=%0d exp=1", o_state); end
        press(3'b001, 8'h03);
        press(3'b001, 8'h20);
        checks++; if (o_led !== 8'h05) begin failures++; $display("FAIL acc_chain got=%h exp=05", o_led); end
        press(3'b100, 8'h00);
        checks++; if (o_acc !== 1'b0 || o_state !== 3'd4) begin failures++; $display("FAIL acc_off got=%b/%0d exp=0/4", o_acc, o_state); end
        press(3'b001, 8'h00);
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL acc_off_return got=%0d exp=0", o_state); end
    endtask

    task automatic test_priority;
        press(3'b100, 8'h00);
        press(3'b001, 8'h11);
        press(3'b011, 8'h22);
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL clr_enter_state got=%0d exp=0", o_state); end
        checks++; if (o_acc !== 1'b1) begin failures++; $display("FAIL clr_keeps_acc got=%b exp=1", o_acc); end
        press(3'b101, 8'h33);
        checks++; if (o_acc !== 1'b0 || o_state !== 3'd0) begin failures++; $display("FAIL acc_enter got=%b/%0d exp=0/0", o_acc, o_state); end
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        logic [5:0] op, bad;
        logic [10:0] e;
        for (int n = 0; n < 16; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = legal_ops[$urandom_range(0, 7)];
            e = alu_ref(a, b, op);
            press(3'b001, a);
            press(3'b001, b);
            if ($urandom_range(0, 3) == 0) begin
                do bad = 6'($urandom); while (bad inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27});
                press(3'b001, {2'($urandom), bad});
                checks++; if (o_state !== 3'd2 || o_err !== 1'b1) begin failures++; $display("FAIL rand_bad_op op=%h got=%0d/%b exp=2/1", bad, o_state, o_err); end
            end
            press(3'b001, {2'($urandom), op});
            checks++; if (o_led !== e[7:0]) begin failures++; $display("FAIL rand_led a=%h b=%h op=%h got=%h exp=%h", a, b, op, o_led, e[7:0]); end
            checks++; if (o_flags !== e[10:8]) begin failures++; $display("FAIL rand_flags a=%h b=%h op=%h got=%b exp=%b", a, b, op, o_flags, e[10:8]); end
            checks++; if (o_valid !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL rand_valid got=%b/%b exp=1/0", o_valid, o_err); end
            press(3'b001, 8'h00);
        end
    endtask

    task automatic test_async_reset;
        press(3'b100, 8'h00);
        run_op(8'h09, 8'h04, 8'h22);
        press(3'b001, 8'h00);
        press(3'b001, 8'h01);
        press(3'b001, 8'h3F);
        checks++; if (o_led !== 8'h05 || o_err !== 1'b1 || o_state !== 3'd2) begin failures++; $display("FAIL pre_reset got=%h/%b/%0d exp=05/1/2", o_led, o_err, o_state); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if ({o_led, o_flags, o_valid, o_err, o_acc} !== 14'd0) begin failures++; $display("FAIL rst_load_op_outputs got=%h exp=0", {o_led, o_flags, o_valid, o_err, o_acc}); end
        checks++; if (o_state !== 3'd0 || dut.op !== 6'h20) begin failures++; $display("FAIL rst_load_op_state got=%0d/%h exp=0/20", o_state, dut.op); end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        run_op(8'h07, 8'h02, 8'h22);
        checks++; if (o_valid !== 1'b1 || o_led !== 8'h05) begin failures++; $display("FAIL pre_reset_show got=%b/%h exp=1/05", o_valid, o_led); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if ({o_led, o_flags, o_valid, o_err, o_acc} !== 14'd0) begin failures++; $display("FAIL rst_show_outputs got=%h exp=0", {o_led, o_flags, o_valid, o_err, o_acc}); end
        checks++; if (o_state !== 3'd0 || dut.op !== 6'h20) begin failures++; $display("FAIL rst_show_state got=%0d/%h exp=0/20", o_state, dut.op); end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_btn = 3'b001;
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        i_btn = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (20) @(negedge i_clk);
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL rst_mid_debounce got=%0d exp=0", o_state); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_clear();
        test_opcode_err();
        test_debounce();
        test_acc();
        test_priority();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
